// File: rtl/lfsr_crypto_pkg.sv
// Shared definitions for the LFSR stream cipher (encryptor and decryptor).
// Holds the frame geometry, pad character, LFSR tap table, the frame FSM
// state type and a tap lookup helper. Out-of-range tap selects map to
// entry 3.
package lfsr_crypto_pkg;

    localparam int FRAME_LEN    = 64;
    localparam int LFSR_W       = 5;
    localparam int MAX_MSG      = 50;
    localparam int PRE_MIN      = 7;
    localparam int PRE_MAX      = 12;
    localparam int NUM_TAPS     = 6;
    localparam int TAP_FALLBACK = 3;

    localparam logic [7:0] PAD_CHAR = 8'h7E;

    localparam logic [LFSR_W-1:0] TAP_TABLE [NUM_TAPS] =
        '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h14, 5'h12};

    typedef enum logic [2:0] {IDLE, PRE, MSG, POST, DONE} state_e;

    function automatic logic [LFSR_W-1:0] tap_lookup(input logic [2:0] sel);
        logic [LFSR_W-1:0] t;
        t = TAP_TABLE[TAP_FALLBACK];
        if (sel < 3'(NUM_TAPS)) t = TAP_TABLE[sel];
        return t;
    endfunction

endpackage

// File: rtl/lfsr5_step.sv
// One step of the 5-bit Fibonacci-style LFSR used by the stream cipher.
// Purely combinational so the encryptor and decryptor share one definition.
// Ports:
//   state_i  current LFSR state
//   taps_i   feedback tap mask
//   next_o   next state: shift left, feedback = parity of tapped bits
module lfsr5_step
    import lfsr_crypto_pkg::*;
(
    input  logic [LFSR_W-1:0] state_i,
    input  logic [LFSR_W-1:0] taps_i,
    output logic [LFSR_W-1:0] next_o
);

    assign next_o = {state_i[LFSR_W-2:0], ^(state_i & taps_i)};

endmodule

// File: rtl/lfsr_encrypt_stream.sv
// LFSR stream encryptor: builds a 64-byte frame (pad preamble, plaintext,
// pad tail), XORs frame byte i with LFSR state i and streams it out over a
// valid/ready interface with a one-entry output register.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start                   begin a frame (honoured in IDLE/DONE only)
//   pre_length, tap_sel,    frame config, sanitised and latched on start
//   lfsr_init, msg_len
//   pt_valid/pt_data/pt_ready   plaintext input handshake
//   ct_valid/ct_data/ct_index/ct_ready  ciphertext output handshake
//   busy, done, cfg_err     status (registered)
// Build option: define LFSR_CT_PARITY_EN to replace ct_data[7] with the
// parity of ct_data[6:0].
module lfsr_encrypt_stream
    import lfsr_crypto_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  pre_length,
    input  logic [2:0]  tap_sel,
    input  logic [4:0]  lfsr_init,
    input  logic [5:0]  msg_len,
    input  logic        pt_valid,
    input  logic [7:0]  pt_data,
    output logic        pt_ready,
    output logic        ct_valid,
    output logic [7:0]  ct_data,
    output logic [5:0]  ct_index,
    input  logic        ct_ready,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
);

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;      // state for the next byte to load
    logic [6:0]        idx_q, idx_d;        // next byte to load; 64 = frame exhausted
    logic [6:0]        pre_len_q, pre_len_d;
    logic [5:0]        msg_len_q, msg_len_d;
    logic [5:0]        msg_cnt_q, msg_cnt_d;
    logic [LFSR_W-1:0] taps_q, taps_d;
    logic              ct_valid_q, ct_valid_d;
    logic [7:0]        ct_data_q, ct_data_d;
    logic [5:0]        ct_index_q, ct_index_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    // Sanitised config as seen on the ports this cycle.
    logic [6:0]        pre_in;
    logic [5:0]        msg_in;
    logic [LFSR_W-1:0] seed_in, taps_in;
    logic              err_in;

    logic [LFSR_W-1:0] lfsr_nxt, seed_nxt;
    logic              can_load, src_avail, load;
    logic [7:0]        src_byte;

    function automatic logic [7:0] encrypt(input logic [7:0] b, input logic [LFSR_W-1:0] s);
        logic [7:0] x;
        x = b ^ {3'b000, s};
`ifdef LFSR_CT_PARITY_EN
        x[7] = ^x[6:0];
`endif
        return x;
    endfunction

    lfsr5_step u_step_run  (.state_i(lfsr_q),  .taps_i(taps_q),  .next_o(lfsr_nxt));
    // Byte 0 is loaded straight from the seed on start, so its successor is
    // needed before the seed is ever registered.
    lfsr5_step u_step_seed (.state_i(seed_in), .taps_i(taps_in), .next_o(seed_nxt));

    always_comb begin
        pre_in  = (pre_length < 8'(PRE_MIN)) ? 7'(PRE_MIN) :
                  (pre_length > 8'(PRE_MAX)) ? 7'(PRE_MAX) : pre_length[6:0];
        msg_in  = (msg_len > 6'(MAX_MSG)) ? 6'(MAX_MSG) : msg_len;
        seed_in = (lfsr_init == '0) ? 5'h01 : lfsr_init;
        taps_in = tap_lookup(tap_sel);
        err_in  = (pre_length < 8'(PRE_MIN)) || (pre_length > 8'(PRE_MAX)) ||
                  (lfsr_init == '0) || (msg_len > 6'(MAX_MSG)) ||
                  (tap_sel >= 3'(NUM_TAPS));
    end

    // Output register takes a new byte whenever it is empty or being drained.
    assign can_load = !ct_valid_q || ct_ready;
    assign pt_ready = (state_q == MSG) && can_load;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        idx_d      = idx_q;
        pre_len_d  = pre_len_q;
        msg_len_d  = msg_len_q;
        msg_cnt_d  = msg_cnt_q;
        taps_d     = taps_q;
        ct_valid_d = ct_valid_q;
        ct_data_d  = ct_data_q;
        ct_index_d = ct_index_q;
        busy_d     = busy_q;
        done_d     = done_q;
        cfg_err_d  = cfg_err_q;

        src_avail = 1'b0;
        src_byte  = PAD_CHAR;
        case (state_q)
            PRE:     src_avail = 1'b1;
            MSG:     begin src_avail = pt_valid; src_byte = pt_data; end
            POST:    src_avail = (idx_q < 7'(FRAME_LEN));
            default: ;
        endcase
        load = can_load && src_avail;

        if (ct_valid_q && ct_ready) ct_valid_d = 1'b0;
        if (load) begin
            ct_valid_d = 1'b1;
            ct_data_d  = encrypt(src_byte, lfsr_q);
            ct_index_d = idx_q[5:0];
            idx_d      = idx_q + 7'd1;
            lfsr_d     = lfsr_nxt;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = PRE;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    cfg_err_d  = err_in;
                    pre_len_d  = pre_in;
                    msg_len_d  = msg_in;
                    taps_d     = taps_in;
                    msg_cnt_d  = '0;
                    // Preamble is at least 7 bytes, so byte 0 is always pad.
                    ct_valid_d = 1'b1;
                    ct_data_d  = encrypt(PAD_CHAR, seed_in);
                    ct_index_d = '0;
                    idx_d      = 7'd1;
                    lfsr_d     = seed_nxt;
                end
            end
            PRE: begin
                if (load && (idx_q + 7'd1 == pre_len_q))
                    state_d = (msg_len_q != '0) ? MSG : POST;
            end
            MSG: begin
                if (load) begin
                    msg_cnt_d = msg_cnt_q + 6'd1;
                    if (msg_cnt_q + 6'd1 == msg_len_q) state_d = POST;
                end
            end
            POST: begin
                if (ct_valid_q && ct_ready && (ct_index_q == 6'(FRAME_LEN - 1))) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lfsr_q     <= '0;
            idx_q      <= '0;
            pre_len_q  <= '0;
            msg_len_q  <= '0;
            msg_cnt_q  <= '0;
            taps_q     <= '0;
            ct_valid_q <= 1'b0;
            ct_data_q  <= '0;
            ct_index_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            idx_q      <= idx_d;
            pre_len_q  <= pre_len_d;
            msg_len_q  <= msg_len_d;
            msg_cnt_q  <= msg_cnt_d;
            taps_q     <= taps_d;
            ct_valid_q <= ct_valid_d;
            ct_data_q  <= ct_data_d;
            ct_index_q <= ct_index_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign ct_valid = ct_valid_q;
    assign ct_data  = ct_data_q;
    assign ct_index = ct_index_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_lfsr_encrypt_stream.sv
`timescale 1ns/1ps
module tb_lfsr_encrypt_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pre_length = '0;
    logic [2:0] tap_sel = '0;
    logic [4:0] lfsr_init = '0;
    logic [5:0] msg_len = '0;
    logic       pt_valid = 1'b0;
    logic [7:0] pt_data = '0;
    logic       pt_ready;
    logic       ct_valid;
    logic [7:0] ct_data;
    logic [5:0] ct_index;
    logic       ct_ready = 1'b0;
    logic       busy, done, cfg_err;

    always #5 clk = ~clk;

    lfsr_encrypt_stream dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pre_length(pre_length),
        .tap_sel(tap_sel), .lfsr_init(lfsr_init), .msg_len(msg_len),
        .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
        .ct_valid(ct_valid), .ct_data(ct_data), .ct_index(ct_index),
        .ct_ready(ct_ready), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [5:0] idx; logic [7:0] data; } exp_t;
    exp_t       exp_arr [256];
    logic [7:0] wr = '0;          // scoreboard write pointer (stimulus side)
    logic [7:0] rd = '0;          // scoreboard read pointer (monitor side)
    logic [7:0] msg_q [$];
    logic [7:0] got [64];
    int         pt_consumed = 0;
    int         pt_base = 0;
    int         acc63_cyc = -1;
    int         rmode = 0;
    int         pmode = 0;
    int         cur_mexp = 0;
    bit         cur_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame bytes and LFSR sequence straight from the
    // frame layout and cipher rules.
    function automatic logic [4:0] ref_taps(input int sel);
        case (sel)
            0: return 5'h1E;
            1: return 5'h1D;
            2: return 5'h1B;
            3: return 5'h17;
            4: return 5'h14;
            5: return 5'h12;
            default: return 5'h17;
        endcase
    endfunction

    task automatic push_frame(input int pre, input int tsel, input int init, input int mlen);
        int p, m;
        logic [4:0] s, t;
        logic [7:0] b, c;
        p = (pre < 7) ? 7 : (pre > 12) ? 12 : pre;
        m = (mlen > 50) ? 50 : mlen;
        s = (init == 0) ? 5'd1 : 5'(init);
        t = ref_taps(tsel);
        for (int i = 0; i < 64; i++) begin
            b = (i >= p && i < p + m) ? msg_q[i - p] : 8'h7E;
            c = b ^ {3'b000, s};
`ifdef LFSR_CT_PARITY_EN
            c[7] = ^c[6:0];
`endif
            exp_arr[wr] = '{idx: 6'(i), data: c};
            wr = wr + 8'd1;
            s = {s[3:0], 1'(($countones(s & t)) % 2)};
        end
        cur_mexp = m;
        cur_err  = (pre < 7) || (pre > 12) || (init == 0) || (mlen > 50) || (tsel > 5);
    endtask

    task automatic fill_msg(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    // Monitor: pops expectations on every accepted byte, checks hold stability.
    bit         hold_chk = 1'b0;
    logic [5:0] prev_idx;
    logic [7:0] prev_data;
    always @(negedge clk) begin
        if (!rst_n) begin
            rd = wr;
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check("hold_valid", 32'(ct_valid), 32'd1);
                check("hold_index", 32'(ct_index), 32'(prev_idx));
                check("hold_data", 32'(ct_data), 32'(prev_data));
            end
            hold_chk  = ct_valid && !ct_ready;
            prev_idx  = ct_index;
            prev_data = ct_data;
            if (ct_valid && ct_ready) begin
                if (rd == wr) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL sb_extra: got byte idx %0d data %0h expected no byte", ct_index, ct_data);
                end else begin
                    check("ct_index", 32'(ct_index), 32'(exp_arr[rd].idx));
                    check("ct_data", 32'(ct_data), 32'(exp_arr[rd].data));
                    rd = rd + 8'd1;
                end
                got[ct_index] = ct_data;
                if (ct_index == 6'd63) acc63_cyc = cyc;
            end
            if (pt_valid && pt_ready) pt_consumed++;
        end
    end

    // Driver for ct_ready / plaintext source, away from the active edge.
    int stall_n = 0;
    int gap_n = 0;
    always @(posedge clk) begin
        int k;
        #2;
        if (start) begin stall_n = 0; gap_n = 0; end
        case (rmode)
            0: ct_ready = 1'b1;
            1: ct_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (ct_valid && ct_index == 6'd10 && stall_n < 3) begin
                    ct_ready = 1'b0;
                    stall_n++;
                end else ct_ready = 1'b1;
            end
        endcase
        k = pt_consumed - pt_base;
        pt_data = (k < msg_q.size()) ? msg_q[k] : 8'($urandom);
        case (pmode)
            0: pt_valid = 1'b1;
            1: pt_valid = ($urandom_range(0, 2) != 0);
            default: begin
                if (k == 3 && gap_n < 2) begin
                    pt_valid = 1'b0;
                    gap_n++;
                end else pt_valid = 1'b1;
            end
        endcase
    end

    task automatic start_frame(input string tag, input int pre, input int tsel, input int init,
                               input int mlen, input int rm, input int pm);
        rmode = rm;
        pmode = pm;
        push_frame(pre, tsel, init, mlen);
        @(posedge clk); #1;
        pt_base    = pt_consumed;
        pre_length = 8'(pre);
        tap_sel    = 3'(tsel);
        lfsr_init  = 5'(init);
        msg_len    = 6'(mlen);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        // Config ports must be ignored once latched.
        pre_length = 8'($urandom);
        tap_sel    = 3'($urandom);
        lfsr_init  = 5'($urandom);
        msg_len    = 6'($urandom);
        @(negedge clk);
        check({tag, "_first_valid"}, 32'(ct_valid), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 32'(cur_err));
    endtask

    task automatic finish_frame(input string tag);
        int n;
        n = 0;
        while (!done && n < 4000) begin @(negedge clk); n++; end
        if (!done) begin
            n_checks++;
            n_errs++;
            $display("FAIL %s_timeout: done still 0 after %0d cycles, expected 1", tag, n);
        end else begin
            check({tag, "_done_lat"}, 32'(cyc), 32'(acc63_cyc + 1));
            check({tag, "_busy_off"}, 32'(busy), 32'd0);
            check({tag, "_drained"}, 32'(rd), 32'(wr));
            check({tag, "_pt_count"}, 32'(pt_consumed - pt_base), 32'(cur_mexp));
            check({tag, "_cfg_err_end"}, 32'(cfg_err), 32'(cur_err));
        end
    endtask

    initial begin
        int n;
        bit found;
        repeat (3) @(negedge clk);
        check("rst_ct_valid", 32'(ct_valid), 32'd0);
        check("rst_ct_data", 32'(ct_data), 32'd0);
        check("rst_ct_index", 32'(ct_index), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_pt_ready", 32'(pt_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Pad-only frame.
        msg_q.delete();
        start_frame("pad", 7, 2, 1, 0, 0, 0);
        finish_frame("pad");
`ifndef LFSR_CT_PARITY_EN
        check("pad_b0", 32'(got[0]), 32'h7F);
        check("pad_b1", 32'(got[1]), 32'h7D);
        check("pad_b2", 32'(got[2]), 32'h78);
        check("pad_b3", 32'(got[3]), 32'h73);
`endif

        // Single-character message "@".
        msg_q.delete();
        msg_q.push_back(8'h40);
        start_frame("at", 7, 2, 1, 1, 0, 0);
        finish_frame("at");
`ifndef LFSR_CT_PARITY_EN
        check("at_b7", 32'(got[7]), 32'h54);
`endif

        // Illegal config: every field overridden, overlong plaintext offered.
        fill_msg(60);
        start_frame("bad", 3, 7, 0, 60, 0, 0);
        finish_frame("bad");
`ifndef LFSR_CT_PARITY_EN
        check("bad_b0", 32'(got[0]), 32'h7F);
`endif

        // Directed backpressure and plaintext gaps.
        fill_msg(20);
        start_frame("bp", 9, 4, int'($urandom_range(1, 31)), 20, 2, 2);
        finish_frame("bp");

        // Randomised frames under random ready/valid.
        for (int f = 0; f < 6; f++) begin
            int ml;
            ml = int'($urandom_range(0, 63));
            fill_msg(ml + 4);
            start_frame("rnd", int'($urandom_range(0, 20)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 31)), ml, 1, 1);
            finish_frame("rnd");
        end

        // start while busy must be ignored; done held afterwards.
        fill_msg(10);
        start_frame("poke", 8, 1, 5, 10, 0, 0);
        repeat (15) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_frame("poke");
        repeat (5) @(negedge clk);
        check("poke_done_held", 32'(done), 32'd1);
        check("poke_busy_held", 32'(busy), 32'd0);

        // Reset in the middle of a frame, then restart.
        fill_msg(30);
        start_frame("rst", 10, 3, 9, 30, 0, 0);
        n = 0;
        found = 1'b0;
        while (!found && n < 500) begin
            @(negedge clk);
            n++;
            if (ct_valid && ct_ready && ct_index == 6'd20) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_errs++;
            $display("FAIL rst_wait: index 20 not accepted within %0d cycles", n);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ct_valid", 32'(ct_valid), 32'd0);
        check("mid_rst_ct_data", 32'(ct_data), 32'd0);
        check("mid_rst_ct_index", 32'(ct_index), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_cfg_err", 32'(cfg_err), 32'd0);
        check("mid_rst_pt_ready", 32'(pt_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        msg_q.delete();
        start_frame("restart", 7, 0, 1, 0, 0, 0);
        finish_frame("restart");
`ifndef LFSR_CT_PARITY_EN
        check("restart_b0", 32'(got[0]), 32'h7F);
        check("restart_b1", 32'(got[1]), 32'h7C);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_encrypt_stream.md
Name: lfsr_encrypt_stream

Overview:
Encryption stage directly upstream of the Lab 5b decryptor; it produces the 64-byte ciphertext frame the decryptor later reads from data memory [128:191].
- Frame layout: pre_length bytes of pad 8'h7E, then the plaintext stream, then 8'h7E to byte 63.
- Each frame byte i is XORed with 5-bit LFSR state i.
- Output is a byte stream with valid/ready handshake, feeding a memory writer.

Parameters:
- FRAME_LEN, 64: bytes per frame.
- LFSR_W, 5: LFSR width.
- MAX_MSG, 50: maximum plaintext length.
- PRE_MIN, 7: minimum preamble length.
- PRE_MAX, 12: maximum preamble length.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- start  in  1  begin a frame; sampled only in IDLE or DONE.
- pre_length  in  8  preamble byte count.
- tap_sel  in  3  selects one of 6 tap patterns.
- lfsr_init  in  5  LFSR seed.
- msg_len  in  6  plaintext byte count.
- pt_valid  in  1  plaintext byte available.
- pt_data  in  8  plaintext byte.
- pt_ready  out  1  plaintext byte consumed this cycle.
- ct_valid  out  1  ciphertext byte held.
- ct_data  out  8  ciphertext byte.
- ct_index  out  6  frame position of ct_data.
- ct_ready  in  1  downstream accepts ct_data.
- busy  out  1  frame in progress.
- done  out  1  frame complete; level.
- cfg_err  out  1  a config field was overridden at start.

Behaviour:
- Reset (async on rst_n low): state=IDLE; all outputs 0; LFSR=0; index counter=0. A reset mid-frame abandons the frame with no further output.
- Tap table:
  - tap_sel 0..5 -> 5'h1E, 1D, 1B, 17, 14, 12.
  - tap_sel > 5 -> 5'h17 (entry 3), and cfg_err is set.
- Config sanitising, latched on start:
  - pre_length clamped to 7..12.
  - lfsr_init==0 -> 5'h01.
  - msg_len > 50 -> 50.
  - Any override sets cfg_err. cfg_err holds until the next start.
  - Config ports are ignored after latching.
- LFSR: next = {s[3:0], ^(s & taps)}; s0 = seed; period 31.
- Cipher: ct_data = frame_byte ^ {3'b000, s}. The LFSR and index advance only on an accepted byte (ct_valid && ct_ready).
- States:
  - IDLE: on start -> PRE; busy=1.
  - PRE: emit pad bytes until index == pre_length. Then -> MSG if msg_len > 0, else -> POST.
  - MSG: emit plaintext bytes until msg_len bytes are consumed, then -> POST.
  - POST: emit pad bytes until index 63 is accepted, then -> DONE.
  - DONE: done=1, busy=0. On start -> PRE; done drops and the new config is latched.
- Output register:
  - One entry, loaded when empty or draining (!ct_valid || ct_ready) and a source byte exists.
  - Pad bytes are always available; plaintext needs pt_valid.
- Handshake:
  - pt_ready = (state==MSG) && (!ct_valid || ct_ready); it is combinational on ct_ready.
  - pt_data is consumed only when pt_valid && pt_ready.
  - ct_data and ct_index are stable while ct_valid && !ct_ready.
- Timing:
  - First ct_valid appears 1 cycle after start.
  - Throughput is 1 byte/cycle under continuous ready.
  - done rises the cycle after byte 63 is accepted.
- start while busy: ignored.
- pt_valid outside MSG: ignored, no consumption.
- Overlong plaintext bytes are never consumed.

Optional Feature:
- Macro: LFSR_CT_PARITY_EN.
- Defined: ct_data[7] = ^ct_data[6:0]; bits 6:0 are unchanged.
- Undefined: ct_data[7] = frame_byte[7] (plain XOR as above).

Decomposition:
- Package lfsr_crypto_pkg holds:
  - PAD_CHAR = 8'h7E;
  - the tap table constant array [6] of 5-bit values;
  - the state enum {IDLE, PRE, MSG, POST, DONE};
  - FRAME_LEN, PRE_MIN, PRE_MAX, MAX_MSG.
- Sub-module lfsr5_step: combinational next-state function, shared with the decryptor.

Test Plan:
- Pad-only frame (pre=7, tap_sel=2, init=01, msg_len=0, ct_ready=1):
  - ct_data bytes 0,1,2,3 = 7F, 7D, 78, 73;
  - 64 bytes total, done at byte 63 + 1 cycle.
- Single-char message "@" (pre=7, tap_sel=2, init=01, pt_data=40):
  - byte 7 = 54 (s7 = 14);
  - exactly one pt_ready&&pt_valid;
  - bytes 8..63 are 7E-based.
- Illegal config (tap_sel=7, init=00, pre=3, msg_len=60):
  - cfg_err=1; uses taps 17, seed 01, pre 7, 50 bytes consumed;
  - byte 0 = 7F.
- Backpressure: ct_ready low for 3 cycles at index 10 and pt_valid low 2 cycles in MSG:
  - ct_data/ct_index held;
  - LFSR not advanced;
  - output identical to the no-stall golden model.
- Reset mid-frame: rst_n low at index 20, then restart with tap_sel=0, init=01:
  - all outputs 0 during reset;
  - new frame bytes 0,1 = 7F, 7C.
- start pulsed while busy: ignored; frame completes unchanged, done then held until the next start.
